// File: rtl/fifo_sync_ex.sv
// rtl/fifo_sync_ex.sv - single-clock FIFO with full-depth capacity, flags, flush and optional FWFT (optional hwm output under FIFO_HWM_EN)
module fifo_sync_ex #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 8,
    parameter int FWFT         = 0,
    parameter int AFULL_LEVEL  = (2 ** ADDR_WIDTH) - 4,
    parameter int AEMPTY_LEVEL = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   data_count
`ifdef FIFO_HWM_EN
    ,
    output logic [ADDR_WIDTH:0]   hwm
`endif
);

    localparam int                DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic [ADDR_WIDTH:0]   mem_count;
    logic [ADDR_WIDTH:0]   count;
    logic                  full_w, empty_w;
    logic                  mem_nonempty;
    logic                  wr_acc, rd_acc, rd_rej, load, mem_we;

    // Occupancy and flags; in FWFT mode the word parked in the output register still counts as held
    always_comb begin
        mem_count    = wptr_q - rptr_q;
        mem_nonempty = (wptr_q != rptr_q);
        if (FWFT != 0) begin
            count   = mem_count + (ADDR_WIDTH + 1)'(dvalid_q);
            full_w  = (count == DEPTH_C);
            empty_w = (count == '0);
        end else begin
            count   = mem_count;
            full_w  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                      (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
            empty_w = (wptr_q == rptr_q);
        end
    end

    // Accept/reject decisions against start-of-cycle flags, then next-state; clr overrides everything but reset
    always_comb begin
        wr_acc = wr && !full_w;
        if (FWFT != 0) begin
            rd_acc = rd && dvalid_q;
            rd_rej = rd && !dvalid_q;
            // refill the output register whenever it is (or is about to become) vacant
            load   = mem_nonempty && (!dvalid_q || rd_acc);
        end else begin
            rd_acc = rd && !empty_w;
            rd_rej = rd && empty_w;
            load   = rd_acc;
        end

        wptr_d = wptr_q + (ADDR_WIDTH + 1)'(wr_acc);
        rptr_d = rptr_q + (ADDR_WIDTH + 1)'(load);
        dout_d = load ? mem_q[rptr_q[ADDR_WIDTH-1:0]] : dout_q;
        if (FWFT != 0) begin
            dvalid_d = load || (dvalid_q && !rd_acc);
        end else begin
            dvalid_d = rd_acc;
        end
        ovf_d  = ovf_q || (wr && full_w);
        unf_d  = unf_q || rd_rej;
        mem_we = wr_acc;

        if (clr) begin
            wptr_d   = '0;
            rptr_d   = '0;
            dout_d   = dout_q;
            dvalid_d = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            mem_we   = 1'b0;
        end
    end

    // Pointer, output and sticky-flag registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage array; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (mem_we && reset) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= din;
        end
    end

`ifdef FIFO_HWM_EN
    logic [ADDR_WIDTH:0] hwm_q, hwm_d;

    // High-water mark follows the registered count one cycle later
    always_comb begin
        hwm_d = (count > hwm_q) ? count : hwm_q;
        if (clr) begin
            hwm_d = '0;
        end
    end

    // High-water mark register
    always_ff @(posedge clk) begin
        if (!reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign dout         = dout_q;
    assign dout_valid   = dvalid_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count >= AFULL_C);
    assign almost_empty = (count <= AEMPTY_C);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_count   = count;

endmodule
